// File: rtl/prefix_flag_sequencer.sv
// rtl/prefix_flag_sequencer.sv - prefix-flag instruction sequencer (FETCH/EXEC)
// Decodes TO/WITH/FROM/ALTx prefixes, tracks flags and selects operand routing.
module prefix_flag_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] opcode,
  input  logic       op_valid,
  input  logic       exec_done,
  output logic       op_ready,
  output logic       to,
  output logic       from,
  output logic       resflags,
  output logic [1:0] ssel,
  output logic [1:0] dsel,
  output logic       alt1,
  output logic       alt2,
  output logic       bflag
);

  typedef enum logic {FETCH, EXEC} state_t;
  typedef enum logic [1:0] {CL_NORMAL, CL_MOVE, CL_MOVES} cls_t;

  state_t state, state_nx;
  cls_t   cls, cls_nx, op_cls;
  logic   alt1_nx, alt2_nx, bflag_nx;

  logic is_to, is_with, is_from, is_alt1, is_alt2, is_alt3;
  logic accept, is_prefix, take_np;

  always_comb begin
    is_to   = (opcode[7:4] == 4'h1);
    is_with = (opcode[7:4] == 4'h2);
    is_from = (opcode[7:4] == 4'hB);
    is_alt1 = (opcode == 8'h3D);
    is_alt2 = (opcode == 8'h3E);
    is_alt3 = (opcode == 8'h3F);
    // With bflag set, TO/FROM become MOVE/MOVES and are no longer prefixes
    is_prefix = (is_to && !bflag) || is_with || (is_from && !bflag) ||
                is_alt1 || is_alt2 || is_alt3;
    if (is_to && bflag)        op_cls = CL_MOVE;
    else if (is_from && bflag) op_cls = CL_MOVES;
    else                       op_cls = CL_NORMAL;
    accept  = rst_n && (state == FETCH) && op_valid;
    take_np = accept && !is_prefix;
  end

  always_comb begin
    state_nx = state;
    cls_nx   = cls;
    alt1_nx  = alt1;
    alt2_nx  = alt2;
    bflag_nx = bflag;
    op_ready = (state == FETCH);
    to       = accept && ((is_to && !bflag) || is_with);
    from     = accept && ((is_from && !bflag) || is_with);
    resflags = !rst_n || ((state == EXEC) && exec_done) || (take_np && exec_done);

    if (resflags) begin
      state_nx = FETCH;
      cls_nx   = CL_NORMAL;
      alt1_nx  = 1'b0;
      alt2_nx  = 1'b0;
      bflag_nx = 1'b0;
    end else if (take_np) begin
      state_nx = EXEC;
      cls_nx   = op_cls;
    end else if (accept) begin
      if (is_with)           bflag_nx = 1'b1;
      if (is_alt1 || is_alt3) alt1_nx = 1'b1;
      if (is_alt2 || is_alt3) alt2_nx = 1'b1;
    end

    // Routing follows the latched class in EXEC, the decoded class when a
    // non-prefix is being accepted, otherwise the default latched/latched.
    ssel = 2'b11;
    dsel = 2'b11;
    if (rst_n) begin
      if (state == EXEC) begin
        if (cls == CL_MOVES) ssel = 2'b01;
        if (cls == CL_MOVE)  dsel = 2'b01;
      end else if (take_np) begin
        if (op_cls == CL_MOVES) ssel = 2'b01;
        if (op_cls == CL_MOVE)  dsel = 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      cls   <= CL_NORMAL;
      alt1  <= 1'b0;
      alt2  <= 1'b0;
      bflag <= 1'b0;
    end else begin
      state <= state_nx;
      cls   <= cls_nx;
      alt1  <= alt1_nx;
      alt2  <= alt2_nx;
      bflag <= bflag_nx;
    end
  end

endmodule
